freq_gen: RTL

- Programmable square-wave generator; the transmit-side counterpart of the frequency meter.
- Takes a 4-digit BCD frequency, the same format the meter displays, plus the same range select.
- Computes the half-period in clk cycles with a sequential BCD-to-binary conversion and a sequential restoring divide.
- Drives a glitch-free square wave that can be looped back into the meter's signal input for self-measurement.

---
 rtl/freq_pkg.sv | 18 +
 rtl/seq_divider.sv | 63 ++++++
 rtl/freq_gen.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/freq_pkg.sv
// Shared definitions for the frequency generator and the frequency meter:
// controller states, BCD digit count and the frequency word width.
package freq_pkg;

  typedef enum logic [2:0] {IDLE, CONV, SCALE, DIV, RUN} state_t;

  localparam int BCD_DIGITS = 4;
  localparam int F_W        = 17;
  localparam int MAX_BCD    = 9;
  localparam int RANGE_MULT = 10;

  // One decimal accumulate step: acc*10 + digit.
  function automatic logic [F_W-1:0] bcd_mac(input logic [F_W-1:0] acc,
                                             input logic [3:0]     digit);
    return acc * F_W'(10) + F_W'(digit);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// The start edge already resolves the first (most significant) bit, so the
// full quotient is available DIV_W-1 cycles after start and done pulses then.
module seq_divider #(
  parameter int DIV_W = 9,
  parameter int F_W   = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [F_W-1:0]   divisor,
  output logic [DIV_W-1:0] quotient,
  output logic             done
);

  localparam int CNT_W = $clog2(DIV_W + 1);

  logic [F_W-1:0]   rem, src_rem, dsr, src_dsr, next_rem;
  logic [DIV_W-1:0] dvd, src_dvd, src_quo;
  logic [F_W:0]     trial, diff;
  logic             fits;
  logic [CNT_W-1:0] steps;

  // Select fresh operands on start, otherwise continue from the held state.
  always_comb begin
    src_rem  = start ? '0 : rem;
    src_dvd  = start ? dividend : dvd;
    src_dsr  = start ? divisor : dsr;
    src_quo  = start ? '0 : quotient;
    trial    = {src_rem, src_dvd[DIV_W-1]};
    diff     = trial - {1'b0, src_dsr};
    fits     = trial >= {1'b0, src_dsr};
    next_rem = fits ? diff[F_W-1:0] : trial[F_W-1:0];
  end

  // Datapath: shift in one quotient bit per active cycle.
  always_ff @(posedge clk) begin
    if (start || steps != '0) begin
      rem      <= next_rem;
      dvd      <= src_dvd << 1;
      dsr      <= src_dsr;
      quotient <= {src_quo[DIV_W-2:0], fits};
    end
  end

  // Step counter and completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      steps <= '0;
      done  <= 1'b0;
    end else if (start) begin
      steps <= CNT_W'(DIV_W - 1);
      done  <= 1'b0;
    end else if (steps != '0) begin
      steps <= steps - 1'b1;
      done  <= (steps == CNT_W'(1));
    end else begin
      done  <= 1'b0;
    end
  end

endmodule

// File: rtl/freq_gen.sv
// Programmable square-wave generator driven by a 4-digit BCD frequency.
// Half-period = (CLK_FREQ/2) / f, computed by BCD conversion, range scaling
// and a sequential divide. A new half-period posted while running is held
// back until the next toggle so no runt level is produced.
// Optional macro FREQ_GEN_TICK_EN adds a one-cycle tick on every rising edge
// of signal.
module freq_gen
  import freq_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] freq_bcd,
  input  logic        range,
  output logic        signal,
  output logic        busy,
  output logic        err
`ifdef FREQ_GEN_TICK_EN
  ,
  output logic        tick
`endif
);

  localparam int DIV_W = $clog2(CLK_FREQ / 2 + 1);
  localparam logic [DIV_W-1:0] DIVIDEND = DIV_W'(CLK_FREQ / 2);

  state_t           state, state_nxt;
  logic [15:0]      bcd_sh;
  logic             range_r;
  logic [1:0]       idx;
  logic [F_W-1:0]   acc, f_scaled;
  logic [3:0]       digit;
  logic             digit_bad, accept, div_start, div_done, post_ok, fail, toggle;
  logic [DIV_W-1:0] quo, half, cnt, pending;
  logic             wave_on, pend_vld;

  assign digit     = bcd_sh[15:12];
  assign digit_bad = digit > 4'(MAX_BCD);
  assign busy      = (state == CONV) || (state == SCALE) || (state == DIV);
  assign accept    = load && !busy;
  assign f_scaled  = range_r ? acc * F_W'(RANGE_MULT) : acc;
  assign div_start = (state == SCALE) && (f_scaled != '0);
  assign post_ok   = (state == DIV) && div_done && (quo != '0);
  assign fail      = ((state == CONV) && digit_bad) ||
                     ((state == SCALE) && (f_scaled == '0)) ||
                     ((state == DIV) && div_done && (quo == '0));
  assign toggle    = wave_on && (cnt == half - 1'b1);

  seq_divider #(.DIV_W(DIV_W), .F_W(F_W)) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (DIVIDEND),
    .divisor  (f_scaled),
    .quotient (quo),
    .done     (div_done)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: conversion, scaling, divide, then run or abort.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, RUN: if (accept) state_nxt = CONV;
      CONV: begin
        if (digit_bad)                          state_nxt = IDLE;
        else if (idx == 2'(BCD_DIGITS - 1))     state_nxt = SCALE;
      end
      SCALE:     state_nxt = (f_scaled == '0) ? IDLE : DIV;
      DIV:       if (div_done) state_nxt = (quo == '0) ? IDLE : RUN;
      default:   state_nxt = IDLE;
    endcase
  end

  // Operand capture and MSD-first BCD accumulation.
  always_ff @(posedge clk) begin
    if (accept) begin
      bcd_sh  <= freq_bcd;
      range_r <= range;
      acc     <= '0;
    end else if (state == CONV) begin
      bcd_sh  <= {bcd_sh[11:0], 4'h0};
      acc     <= bcd_mac(acc, digit);
    end
    if (post_ok && wave_on && !toggle) pending <= quo;
  end

  // Error flag, digit index, waveform counter and result posting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err      <= 1'b0;
      idx      <= '0;
      wave_on  <= 1'b0;
      pend_vld <= 1'b0;
      half     <= '0;
      cnt      <= '0;
      signal   <= 1'b0;
`ifdef FREQ_GEN_TICK_EN
      tick     <= 1'b0;
`endif
    end else begin
`ifdef FREQ_GEN_TICK_EN
      tick <= 1'b0;
`endif
      if (accept) begin
        err <= 1'b0;
        idx <= '0;
      end else if (state == CONV) begin
        idx <= idx + 1'b1;
      end
      if (wave_on) begin
        if (toggle) begin
          signal   <= ~signal;
          cnt      <= '0;
          pend_vld <= 1'b0;
          if (post_ok)       half <= quo;
          else if (pend_vld) half <= pending;
`ifdef FREQ_GEN_TICK_EN
          tick     <= ~signal;
`endif
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
      if (fail) begin
        err      <= 1'b1;
        wave_on  <= 1'b0;
        pend_vld <= 1'b0;
        signal   <= 1'b0;
        cnt      <= '0;
`ifdef FREQ_GEN_TICK_EN
        tick     <= 1'b0;
`endif
      end else if (post_ok) begin
        if (!wave_on) begin
          half    <= quo;
          wave_on <= 1'b1;
          signal  <= 1'b1;
          cnt     <= '0;
`ifdef FREQ_GEN_TICK_EN
          tick    <= 1'b1;
`endif
        end else if (!toggle) begin
          pend_vld <= 1'b1;
        end
      end
    end
  end

endmodule
